// File: rtl/ascii_to_morse_if.sv
// Character handshake and key/status bundle between a character source and the Morse transmitter.
interface ascii_to_morse_if;
    logic [7:0] ascii_in;
    logic       char_valid;
    logic       char_ready;
    logic       morse_out;
    logic [9:0] code_out;
    logic       busy;
    logic       err;

    modport master (
        output ascii_in, char_valid,
        input  char_ready, morse_out, code_out, busy, err
    );

    modport slave (
        input  ascii_in, char_valid,
        output char_ready, morse_out, code_out, busy, err
    );
endinterface

// File: rtl/ascii_to_morse_tx.sv
// ASCII to Morse keyer: one character per handshake, keyed serially on morse_out with unit timing.
// Defining TONE_OUT_EN adds a square-wave tone_out that runs while the key is down.
module ascii_to_morse_tx #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int CNT_W = $clog2(7 * UNIT_CYCLES + 1)
`ifdef TONE_OUT_EN
    , parameter int TONE_HALF_CYCLES = 25_000
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    ascii_to_morse_if.slave bus
`ifdef TONE_OUT_EN
    , output logic          tone_out
`endif
);

    // IDLE wait char | MARK key down | SGAP symbol gap | LGAP letter gap | WGAP word gap
    typedef enum logic [2:0] {IDLE, MARK, SGAP, LGAP, WGAP} state_t;

    localparam logic [CNT_W-1:0] ONE_U   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] THREE_U = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEVEN_U = CNT_W'(7 * UNIT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0]       shreg, shreg_nxt, shifted, code_lut;
    logic [9:0]       code_q, code_nxt;
    logic             morse_q, morse_nxt;
    logic             err_q, err_nxt;

    function automatic logic [9:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            8'h41: lookup = 10'b10_11_00_00_00;
            8'h42: lookup = 10'b11_10_10_10_00;
            8'h43: lookup = 10'b11_10_11_10_00;
            8'h44: lookup = 10'b11_10_10_00_00;
            8'h45: lookup = 10'b10_00_00_00_00;
            8'h46: lookup = 10'b10_10_11_10_00;
            8'h47: lookup = 10'b11_11_10_00_00;
            8'h48: lookup = 10'b10_10_10_10_00;
            8'h49: lookup = 10'b10_10_00_00_00;
            8'h4A: lookup = 10'b10_11_11_11_00;
            8'h4B: lookup = 10'b11_10_11_00_00;
            8'h4C: lookup = 10'b10_11_10_10_00;
            8'h4D: lookup = 10'b11_11_00_00_00;
            8'h4E: lookup = 10'b11_10_00_00_00;
            8'h4F: lookup = 10'b11_11_11_00_00;
            8'h50: lookup = 10'b10_11_11_10_00;
            8'h51: lookup = 10'b11_11_10_11_00;
            8'h52: lookup = 10'b10_11_10_00_00;
            8'h53: lookup = 10'b10_10_10_00_00;
            8'h54: lookup = 10'b11_00_00_00_00;
            8'h55: lookup = 10'b10_10_11_00_00;
            8'h56: lookup = 10'b10_10_10_11_00;
            8'h57: lookup = 10'b10_11_11_00_00;
            8'h58: lookup = 10'b11_10_10_11_00;
            8'h59: lookup = 10'b11_10_11_11_00;
            8'h5A: lookup = 10'b11_11_10_10_00;
            8'h30: lookup = 10'b11_11_11_11_11;
            8'h31: lookup = 10'b10_11_11_11_11;
            8'h32: lookup = 10'b10_10_11_11_11;
            8'h33: lookup = 10'b10_10_10_11_11;
            8'h34: lookup = 10'b10_10_10_10_11;
            8'h35: lookup = 10'b10_10_10_10_10;
            8'h36: lookup = 10'b11_10_10_10_10;
            8'h37: lookup = 10'b11_11_10_10_10;
            8'h38: lookup = 10'b11_11_11_10_10;
            8'h39: lookup = 10'b11_11_11_11_10;
            default: lookup = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sym_len(input logic [1:0] pair);
        sym_len = (pair == 2'b11) ? THREE_U : ONE_U;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            code_q  <= '0;
            morse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            code_q  <= code_nxt;
            morse_q <= morse_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        code_lut  = lookup(bus.ascii_in);
        shifted   = {shreg[7:0], 2'b00};
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        code_nxt  = code_q;
        morse_nxt = morse_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.char_valid) begin
                    if (bus.ascii_in == 8'h20) begin
                        state_nxt = WGAP;
                        cnt_nxt   = SEVEN_U;
                        code_nxt  = '0;
                    end else if (code_lut != '0) begin
                        state_nxt = MARK;
                        shreg_nxt = code_lut;
                        code_nxt  = code_lut;
                        morse_nxt = 1'b1;
                        cnt_nxt   = sym_len(code_lut[9:8]);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    shreg_nxt = shifted;
                    morse_nxt = 1'b0;
                    if (shifted[9:8] != 2'b00) begin
                        state_nxt = SGAP;
                        cnt_nxt   = ONE_U;
                    end else begin
                        state_nxt = LGAP;
                        cnt_nxt   = THREE_U;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SGAP: begin
                if (cnt == '0) begin
                    state_nxt = MARK;
                    morse_nxt = 1'b1;
                    cnt_nxt   = sym_len(shreg[9:8]);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LGAP, WGAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    code_nxt  = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                morse_nxt = 1'b0;
                code_nxt  = '0;
            end
        endcase
    end

    assign bus.char_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.morse_out  = morse_q;
    assign bus.code_out   = code_q;
    assign bus.err        = err_q;

`ifdef TONE_OUT_EN
    localparam int TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

    logic [TW-1:0] tone_div;
    logic          tone_q;

    // Divider restarts on every mark so each tone burst begins with the same phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_div <= '0;
            tone_q   <= 1'b0;
        end else if (!morse_q) begin
            tone_div <= '0;
            tone_q   <= 1'b0;
        end else if (tone_div == TW'(TONE_HALF_CYCLES - 1)) begin
            tone_div <= '0;
            tone_q   <= ~tone_q;
        end else begin
            tone_div <= tone_div + TW'(1);
        end
    end

    assign tone_out = tone_q;
`endif

endmodule

// File: tb/tb_ascii_to_morse_tx.sv
// Self-checking bench for ascii_to_morse_tx: table vectors, random characters against a
// dot/dash string model, back-to-back handshake and mid-character reset sequences.
module tb_ascii_to_morse_tx;
    localparam int U = 4;

    logic clk = 1'b0;
    logic rst_n;
    ascii_to_morse_if bus();
`ifdef TONE_OUT_EN
    logic tone;
`endif

    ascii_to_morse_tx #(
        .UNIT_CYCLES(U)
`ifdef TONE_OUT_EN
        , .TONE_HALF_CYCLES(3)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef TONE_OUT_EN
        , .tone_out(tone)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic [9:0] code;
        bit         err;
        int         dur;
    } vec_t;

    vec_t  vecs[12];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    exp_wave[$];

    string ltr[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string dig[10] = '{"-----", ".----", "..---", "...--", "....-",
                       ".....", "-....", "--...", "---..", "----."};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: code and key waveform straight from the dot/dash spelling of the character.
    task automatic build_model(input logic [7:0] c, output logic [9:0] code, output bit e);
        string      p;
        logic [7:0] u;
        exp_wave.delete();
        code = '0;
        e    = 1'b0;
        p    = "";
        u    = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u == 8'h20) begin
            repeat (7 * U) exp_wave.push_back(1'b0);
            return;
        end
        if (u >= 8'h41 && u <= 8'h5A) p = ltr[int'(u) - 65];
        else if (u >= 8'h30 && u <= 8'h39) p = dig[int'(u) - 48];
        else begin
            e = 1'b1;
            return;
        end
        for (int i = 0; i < p.len(); i++) begin
            bit dash;
            dash = (p[i] == 8'h2D);
            code[9 - 2 * i -: 2] = dash ? 2'b11 : 2'b10;
            repeat (dash ? 3 * U : U) exp_wave.push_back(1'b1);
            repeat ((i == p.len() - 1) ? 3 * U : U) exp_wave.push_back(1'b0);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && !bus.char_ready; i++) @(negedge clk);
        chk("ready_timeout", {31'd0, bus.char_ready}, 32'd1);
    endtask

    task automatic run_char(input logic [7:0] ch, input logic [9:0] ecode, input bit eerr,
                            input int edur, input string tag);
        int   dur;
        int   mism;
        logic expm;
        wait_ready();
        bus.ascii_in   = ch;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        bus.ascii_in   = 8'($urandom);
        @(negedge clk);
        chk($sformatf("%s_code_%02h", tag, ch), {22'd0, bus.code_out}, {22'd0, ecode});
        chk($sformatf("%s_err_%02h", tag, ch), {31'd0, bus.err}, {31'd0, eerr});
        chk($sformatf("%s_ready1_%02h", tag, ch), {31'd0, bus.char_ready}, {31'd0, eerr});
        dur  = 0;
        mism = 0;
        for (int c = 1; c <= 200; c++) begin
            if (!bus.busy) break;
            dur++;
            expm = (c <= exp_wave.size()) ? exp_wave[c - 1] : 1'b0;
            if (bus.morse_out !== expm || bus.char_ready !== 1'b0) mism++;
            @(negedge clk);
        end
        chk($sformatf("%s_dur_%02h", tag, ch), dur, edur);
        chk($sformatf("%s_wave_%02h", tag, ch), mism, 0);
        @(negedge clk);
        chk($sformatf("%s_end_ready_%02h", tag, ch), {31'd0, bus.char_ready}, 32'd1);
        chk($sformatf("%s_end_code_%02h", tag, ch), {22'd0, bus.code_out}, 32'd0);
        chk($sformatf("%s_end_key_%02h", tag, ch), {31'd0, bus.morse_out}, 32'd0);
        chk($sformatf("%s_end_err_%02h", tag, ch), {31'd0, bus.err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] mcode;
        bit         merr;
        logic [7:0] ch;
        int         first_ready, rises, highs;
        logic       prev, m26;
        logic [9:0] c26;

        vecs[0]  = '{8'h45, 10'b10_00_00_00_00, 1'b0, 16};
        vecs[1]  = '{8'h41, 10'b10_11_00_00_00, 1'b0, 32};
        vecs[2]  = '{8'h61, 10'b10_11_00_00_00, 1'b0, 32};
        vecs[3]  = '{8'h30, 10'b11_11_11_11_11, 1'b0, 88};
        vecs[4]  = '{8'h20, 10'b00_00_00_00_00, 1'b0, 28};
        vecs[5]  = '{8'h23, 10'b00_00_00_00_00, 1'b1, 0};
        vecs[6]  = '{8'h54, 10'b11_00_00_00_00, 1'b0, 24};
        vecs[7]  = '{8'h35, 10'b10_10_10_10_10, 1'b0, 48};
        vecs[8]  = '{8'h7A, 10'b11_11_10_10_00, 1'b0, 56};
        vecs[9]  = '{8'h39, 10'b11_11_11_11_10, 1'b0, 80};
        vecs[10] = '{8'h7E, 10'b00_00_00_00_00, 1'b1, 0};
        vecs[11] = '{8'h51, 10'b11_11_10_11_00, 1'b0, 64};

        rst_n          = 1'b0;
        bus.ascii_in   = 8'h00;
        bus.char_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.char_ready}, 32'd1);
        chk("rst_busy",  {31'd0, bus.busy},       32'd0);
        chk("rst_key",   {31'd0, bus.morse_out},  32'd0);
        chk("rst_code",  {22'd0, bus.code_out},   32'd0);
        chk("rst_err",   {31'd0, bus.err},        32'd0);

        for (int i = 0; i < 12; i++) begin
            build_model(vecs[i].ch, mcode, merr);
            run_char(vecs[i].ch, vecs[i].code, vecs[i].err, vecs[i].dur, "vec");
        end

        for (int i = 0; i < 40; i++) begin
            ch = 8'($urandom_range(0, 127));
            build_model(ch, mcode, merr);
            run_char(ch, mcode, merr, exp_wave.size(), "rnd");
        end

        // T then E with char_valid held high: E must wait for T's letter gap to finish.
        wait_ready();
        bus.ascii_in   = 8'h54;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ascii_in = 8'h45;
        first_ready = 0;
        rises = 0;
        highs = 0;
        prev  = 1'b0;
        m26   = 1'b0;
        c26   = '0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.char_ready && first_ready == 0) first_ready = c;
            if (bus.morse_out && !prev) rises++;
            if (bus.morse_out) highs++;
            prev = bus.morse_out;
            if (c == 26) begin
                m26 = bus.morse_out;
                c26 = bus.code_out;
                bus.char_valid = 1'b0;
            end
        end
        chk("b2b_ready_cycle", first_ready, 25);
        chk("b2b_mark_count", rises, 2);
        chk("b2b_high_cycles", highs, 16);
        chk("b2b_e_key", {31'd0, m26}, 32'd1);
        chk("b2b_e_code", {22'd0, c26}, {22'd0, 10'b10_00_00_00_00});

        // Reset asserted in the middle of a T dash.
        wait_ready();
        bus.ascii_in   = 8'h54;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_key_before_rst", {31'd0, bus.morse_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key",   {31'd0, bus.morse_out},  32'd0);
        chk("mid_rst_code",  {22'd0, bus.code_out},   32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy},       32'd0);
        chk("mid_rst_ready", {31'd0, bus.char_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_model(8'h45, mcode, merr);
        run_char(8'h45, 10'b10_00_00_00_00, 1'b0, 16, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
